seg_mem_sequencer: RTL and testbench

SEG_MEM_SEQUENCER -- requirements
Module: seg_mem_sequencer

---
 rtl/seg_mem_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_seg_mem_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_mem_sequencer.sv
// seg_mem_sequencer
//   Breaks one segmented vector memory request (nf+1 fields, elements
//   vstart..vl-1) into single-element micro-ops. Micro-ops are issued
//   element-major: every field of element i goes out before element i+1.
//   Responses come back in order. A small FIFO keeps the vstart of each
//   micro-op that is still in flight, so the first faulting element can be
//   reported.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                synchronous abort, takes priority over everything
//   req_*                  segment request (valid/ready), nf, vstart, vl, vd, is_load
//   uop_*                  micro-op (valid/ready), vstart, vl, vd, field index
//   uop_resp_valid_i/exc_i in-order micro-op responses
//   backend_idle_i         backend has fully drained
//   done_*                 one-cycle completion pulse with exception info
//   busy_o                 high whenever a request is being worked on
//
// state    | meaning
// ---------+------------------------------------------------------------
// StIdle   | waiting for a request, req_ready_o high
// StIssue  | issuing micro-ops, limited by the outstanding count
// StDrain  | no more issue; waiting for responses and an idle backend
// StDone   | one-cycle completion pulse on done_valid_o

module seg_mem_sequencer #(
    parameter int unsigned NrFieldsW      = 3,
    parameter int unsigned VlenW          = 16,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,

    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [NrFieldsW-1:0] req_nf_i,
    input  logic [VlenW-1:0]     req_vstart_i,
    input  logic [VlenW-1:0]     req_vl_i,
    input  logic [4:0]           req_vd_i,
    input  logic                 req_is_load_i,

    output logic                 uop_valid_o,
    input  logic                 uop_ready_i,
    output logic [VlenW-1:0]     uop_vstart_o,
    output logic [VlenW:0]       uop_vl_o,
    output logic [4:0]           uop_vd_o,
    output logic [NrFieldsW-1:0] uop_field_o,

    input  logic                 uop_resp_valid_i,
    input  logic                 uop_resp_exc_i,
    input  logic                 backend_idle_i,

    output logic                 done_valid_o,
    output logic                 done_exc_o,
    output logic [VlenW-1:0]     done_vstart_o,
    output logic                 done_is_load_o,
    output logic                 busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [NrFieldsW-1:0] nf_q, nf_d;
    logic [NrFieldsW-1:0] field_q, field_d;
    logic [VlenW-1:0]     vstart_q, vstart_d;
    logic [VlenW-1:0]     vl_q, vl_d;
    logic [VlenW-1:0]     done_vstart_q, done_vstart_d;
    logic [4:0]           vd_q, vd_d;
    logic                 is_load_q, is_load_d;
    logic                 exc_q, exc_d;
    logic [CntW-1:0]      out_cnt_q, out_cnt_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [VlenW-1:0]     fifo_q [MaxOutstanding];
    logic [VlenW-1:0]     fifo_d [MaxOutstanding];

    logic                 uop_valid;
    logic                 uop_fire;
    logic                 resp_fire;
    logic                 last_uop;
    logic [VlenW:0]       vstart_inc;
    logic [4:0]           field5;

    assign vstart_inc = {1'b0, vstart_q} + (VlenW+1)'(1);
    assign field5     = 5'(field_q);

    // Issue stops as soon as a fault is known; the outstanding limit also
    // guarantees the tracker FIFO can never overflow.
    assign uop_valid = (state_q == StIssue) && !exc_q && (out_cnt_q < CntMax);
    assign uop_fire  = uop_valid && uop_ready_i;
    // Stray responses with nothing in flight are dropped.
    assign resp_fire = uop_resp_valid_i && (out_cnt_q != '0);
    assign last_uop  = (field_q == nf_q) && (vstart_inc == {1'b0, vl_q});

    always_comb begin
        state_d       = state_q;
        nf_d          = nf_q;
        field_d       = field_q;
        vstart_d      = vstart_q;
        vl_d          = vl_q;
        done_vstart_d = done_vstart_q;
        vd_d          = vd_q;
        is_load_d     = is_load_q;
        exc_d         = exc_q;
        out_cnt_d     = out_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_d        = fifo_q;

        case ({uop_fire, resp_fire})
            2'b10:   out_cnt_d = out_cnt_q + CntW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CntW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase

        if (uop_fire) begin
            fifo_d[wr_ptr_q] = vstart_q;
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (resp_fire) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
        end

        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    nf_d      = req_nf_i;
                    vl_d      = req_vl_i;
                    vd_d      = req_vd_i;
                    is_load_d = req_is_load_i;
                    vstart_d  = req_vstart_i;
                    field_d   = '0;
                    exc_d     = 1'b0;
                    if (req_vstart_i >= req_vl_i) begin
                        done_vstart_d = req_vl_i;
                        state_d       = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (uop_fire) begin
                    if (field_q == nf_q) begin
                        field_d  = '0;
                        vstart_d = vstart_q + VlenW'(1);
                    end else begin
                        field_d = field_q + NrFieldsW'(1);
                    end
                    if (last_uop) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // First faulting response wins; the FIFO head is the element it
        // belongs to because responses return in issue order.
        if (resp_fire && uop_resp_exc_i && !exc_q) begin
            exc_d         = 1'b1;
            done_vstart_d = fifo_q[rd_ptr_q];
            if (state_q == StIssue) begin
                state_d = StDrain;
            end
        end

        // Uses the next-cycle count so a final response in this cycle counts.
        if ((state_q == StDrain) && (out_cnt_d == '0) && backend_idle_i) begin
            state_d = StDone;
            if (!exc_d) begin
                done_vstart_d = vl_q;
            end
        end

        if (flush_i) begin
            state_d       = StIdle;
            field_d       = '0;
            vstart_d      = '0;
            done_vstart_d = '0;
            exc_d         = 1'b0;
            out_cnt_d     = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            fifo_d        = '{default: '0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            nf_q          <= '0;
            field_q       <= '0;
            vstart_q      <= '0;
            vl_q          <= '0;
            done_vstart_q <= '0;
            vd_q          <= '0;
            is_load_q     <= 1'b0;
            exc_q         <= 1'b0;
            out_cnt_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_q        <= '{default: '0};
        end else begin
            state_q       <= state_d;
            nf_q          <= nf_d;
            field_q       <= field_d;
            vstart_q      <= vstart_d;
            vl_q          <= vl_d;
            done_vstart_q <= done_vstart_d;
            vd_q          <= vd_d;
            is_load_q     <= is_load_d;
            exc_q         <= exc_d;
            out_cnt_q     <= out_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_q        <= fifo_d;
        end
    end

    // All outputs decode from registers only. Payloads are zeroed when not
    // valid; they only move on a handshake, so they hold under backpressure.
    assign req_ready_o    = (state_q == StIdle);
    assign busy_o         = (state_q != StIdle);
    assign uop_valid_o    = uop_valid;
    assign uop_vstart_o   = uop_valid ? vstart_q : '0;
    assign uop_vl_o       = uop_valid ? vstart_inc : '0;
    assign uop_vd_o       = uop_valid ? (vd_q + field5) : '0;
    assign uop_field_o    = uop_valid ? field_q : '0;
    assign done_valid_o   = (state_q == StDone);
    assign done_exc_o     = done_valid_o && exc_q;
    assign done_is_load_o = done_valid_o && is_load_q;
    assign done_vstart_o  = done_valid_o ? done_vstart_q : '0;

endmodule

// File: tb/tb_seg_mem_sequencer.sv
`timescale 1ns/1ps
module tb_seg_mem_sequencer;

    localparam int NrFieldsW      = 3;
    localparam int VlenW          = 16;
    localparam int MaxOutstanding = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 flush_i = 1'b0;
    logic                 req_valid_i = 1'b0;
    logic                 req_ready_o;
    logic [NrFieldsW-1:0] req_nf_i = '0;
    logic [VlenW-1:0]     req_vstart_i = '0;
    logic [VlenW-1:0]     req_vl_i = '0;
    logic [4:0]           req_vd_i = '0;
    logic                 req_is_load_i = 1'b0;
    logic                 uop_valid_o;
    logic                 uop_ready_i = 1'b1;
    logic [VlenW-1:0]     uop_vstart_o;
    logic [VlenW:0]       uop_vl_o;
    logic [4:0]           uop_vd_o;
    logic [NrFieldsW-1:0] uop_field_o;
    logic                 uop_resp_valid_i = 1'b0;
    logic                 uop_resp_exc_i = 1'b0;
    logic                 backend_idle_i = 1'b1;
    logic                 done_valid_o;
    logic                 done_exc_o;
    logic [VlenW-1:0]     done_vstart_o;
    logic                 done_is_load_o;
    logic                 busy_o;

    always #5 clk_i = ~clk_i;

    seg_mem_sequencer #(
        .NrFieldsW      (NrFieldsW),
        .VlenW          (VlenW),
        .MaxOutstanding (MaxOutstanding)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_nf_i         (req_nf_i),
        .req_vstart_i     (req_vstart_i),
        .req_vl_i         (req_vl_i),
        .req_vd_i         (req_vd_i),
        .req_is_load_i    (req_is_load_i),
        .uop_valid_o      (uop_valid_o),
        .uop_ready_i      (uop_ready_i),
        .uop_vstart_o     (uop_vstart_o),
        .uop_vl_o         (uop_vl_o),
        .uop_vd_o         (uop_vd_o),
        .uop_field_o      (uop_field_o),
        .uop_resp_valid_i (uop_resp_valid_i),
        .uop_resp_exc_i   (uop_resp_exc_i),
        .backend_idle_i   (backend_idle_i),
        .done_valid_o     (done_valid_o),
        .done_exc_o       (done_exc_o),
        .done_vstart_o    (done_vstart_o),
        .done_is_load_o   (done_is_load_o),
        .busy_o           (busy_o)
    );

    // exc_at: 1-based index of the faulting response (0 = none);
    // sticky: every response from exc_at on also faults.
    typedef struct {
        logic [2:0]  nf;
        logic [15:0] vstart;
        logic [15:0] vl;
        logic [4:0]  vd;
        logic        is_load;
        int          exc_at;
        bit          sticky;
        int          exp_uops;
        logic        exp_exc;
        logic [15:0] exp_dvs;
        int          exp_done_cyc;
    } vec_t;

    vec_t vecs [8];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"},  32'(req_ready_o),   32'd1);
        chk({tag, "_uop_valid"},  32'(uop_valid_o),   32'd0);
        chk({tag, "_done_valid"}, 32'(done_valid_o),  32'd0);
        chk({tag, "_busy"},       32'(busy_o),        32'd0);
        chk({tag, "_uop_vstart"}, 32'(uop_vstart_o),  32'd0);
        chk({tag, "_uop_vl"},     32'(uop_vl_o),      32'd0);
        chk({tag, "_uop_vd"},     32'(uop_vd_o),      32'd0);
        chk({tag, "_uop_field"},  32'(uop_field_o),   32'd0);
        chk({tag, "_done_vs"},    32'(done_vstart_o), 32'd0);
        chk({tag, "_done_exc"},   32'(done_exc_o),    32'd0);
    endtask

    task automatic start_req(input logic [2:0] nf, input logic [15:0] vs, input logic [15:0] vl,
                             input logic [4:0] vd, input logic ld);
        req_valid_i   = 1'b1;
        req_nf_i      = nf;
        req_vstart_i  = vs;
        req_vl_i      = vl;
        req_vd_i      = vd;
        req_is_load_i = ld;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    // Called at a negedge with the DUT idle. Responds one cycle after each
    // handshake, ready always high, backend always idle.
    task automatic run_vec(input int idx, input vec_t v);
        int  exp_vs, exp_f, n_uop, n_resp, done_cyc;
        bit  pend, done_seen;
        string t;
        t = $sformatf("v%0d", idx);
        exp_vs = int'(v.vstart); exp_f = 0; n_uop = 0; n_resp = 0;
        pend = 0; done_seen = 0; done_cyc = -1;
        uop_ready_i = 1'b1;
        backend_idle_i = 1'b1;
        chk({t, "_ready_before"}, 32'(req_ready_o), 32'd1);
        start_req(v.nf, v.vstart, v.vl, v.vd, v.is_load);
        for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
            uop_resp_valid_i = pend;
            uop_resp_exc_i   = pend && (v.exc_at > 0) &&
                               (v.sticky ? (n_resp + 1 >= v.exc_at) : (n_resp + 1 == v.exc_at));
            if (pend) n_resp++;
            pend = 0;
            if (uop_valid_o) begin
                chk({t, "_uop_vstart"}, 32'(uop_vstart_o), 32'(exp_vs));
                chk({t, "_uop_vl"},     32'(uop_vl_o),     32'(exp_vs + 1));
                chk({t, "_uop_field"},  32'(uop_field_o),  32'(exp_f));
                chk({t, "_uop_vd"},     32'(uop_vd_o),     32'((int'(v.vd) + exp_f) % 32));
                if (exp_f == int'(v.nf)) begin
                    exp_f = 0;
                    exp_vs++;
                end else begin
                    exp_f++;
                end
                n_uop++;
                pend = 1;
            end
            if (done_valid_o) begin
                done_seen = 1;
                done_cyc  = cyc;
                chk({t, "_done_exc"},     32'(done_exc_o),     32'(v.exp_exc));
                chk({t, "_done_vstart"},  32'(done_vstart_o),  32'(v.exp_dvs));
                chk({t, "_done_is_load"}, 32'(done_is_load_o), 32'(v.is_load));
            end
            @(negedge clk_i);
        end
        uop_resp_valid_i = 1'b0;
        uop_resp_exc_i   = 1'b0;
        chk({t, "_done_seen"},    32'(done_seen), 32'd1);
        chk({t, "_uop_count"},    32'(n_uop),     32'(v.exp_uops));
        chk({t, "_done_latency"}, 32'(done_cyc),  32'(v.exp_done_cyc));
        chk({t, "_done_pulse"},   32'(done_valid_o), 32'd0);
        chk({t, "_busy_after"},   32'(busy_o),       32'd0);
        chk({t, "_ready_after"},  32'(req_ready_o),  32'd1);
    endtask

    initial begin
        int hs;
        int dones;

        //          nf    vstart  vl     vd     ld    exc st  uops exc  dvs    cyc
        vecs[0] = '{3'd2, 16'd0, 16'd2, 5'd8,  1'b1, 0,  0,  6,   1'b0, 16'd2, 7};
        vecs[1] = '{3'd1, 16'd0, 16'd4, 5'd3,  1'b0, 5,  0,  6,   1'b1, 16'd2, 7};
        vecs[2] = '{3'd0, 16'd5, 16'd5, 5'd0,  1'b1, 0,  0,  0,   1'b0, 16'd5, 0};
        vecs[3] = '{3'd1, 16'd0, 16'd1, 5'd31, 1'b0, 0,  0,  2,   1'b0, 16'd1, 3};
        vecs[4] = '{3'd0, 16'd3, 16'd6, 5'd0,  1'b1, 0,  0,  3,   1'b0, 16'd6, 4};
        vecs[5] = '{3'd3, 16'd7, 16'd2, 5'd4,  1'b0, 0,  0,  0,   1'b0, 16'd2, 0};
        vecs[6] = '{3'd7, 16'd0, 16'd1, 5'd28, 1'b1, 1,  0,  2,   1'b1, 16'd0, 3};
        vecs[7] = '{3'd1, 16'd1, 16'd3, 5'd10, 1'b0, 2,  1,  3,   1'b1, 16'd1, 4};

        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check_idle_outputs("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        // Outstanding limit: no responses, only MaxOutstanding uops go out.
        uop_ready_i = 1'b1;
        start_req(3'd7, 16'd0, 16'd4, 5'd0, 1'b0);
        hs = 0;
        for (int c = 0; c < 10; c++) begin
            if (uop_valid_o) hs++;
            @(negedge clk_i);
        end
        chk("limit_uops", 32'(hs), 32'd4);
        chk("limit_valid_low", 32'(uop_valid_o), 32'd0);
        uop_resp_valid_i = 1'b1;
        @(negedge clk_i);
        uop_resp_valid_i = 1'b0;
        hs = 0;
        for (int c = 0; c < 5; c++) begin
            if (uop_valid_o) begin
                hs++;
                chk("limit_extra_field", 32'(uop_field_o), 32'd4);
            end
            @(negedge clk_i);
        end
        chk("limit_extra_uops", 32'(hs), 32'd1);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("limit_flush_busy", 32'(busy_o), 32'd0);

        // Backpressure stability, then flush with 3 outstanding.
        start_req(3'd7, 16'd0, 16'd4, 5'd0, 1'b1);
        repeat (3) @(negedge clk_i);
        uop_ready_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk("stall_valid",  32'(uop_valid_o),  32'd1);
            chk("stall_field",  32'(uop_field_o),  32'd3);
            chk("stall_vstart", 32'(uop_vstart_o), 32'd0);
            chk("stall_vd",     32'(uop_vd_o),     32'd3);
            chk("stall_vl",     32'(uop_vl_o),     32'd1);
            @(negedge clk_i);
        end
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        uop_ready_i = 1'b1;
        chk("flush_busy",      32'(busy_o),       32'd0);
        chk("flush_req_ready", 32'(req_ready_o),  32'd1);
        chk("flush_uop_valid", 32'(uop_valid_o),  32'd0);
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            if (done_valid_o) dones++;
            @(negedge clk_i);
        end
        chk("flush_no_done", 32'(dones), 32'd0);
        run_vec(10, vecs[0]);

        // DRAIN waits for backend_idle_i even with nothing outstanding.
        backend_idle_i = 1'b0;
        start_req(3'd0, 16'd0, 16'd1, 5'd0, 1'b0);
        chk("drain_first_uop", 32'(uop_valid_o), 32'd1);
        @(negedge clk_i);
        uop_resp_valid_i = 1'b1;
        @(negedge clk_i);
        uop_resp_valid_i = 1'b0;
        dones = 0;
        for (int c = 0; c < 3; c++) begin
            if (done_valid_o) dones++;
            chk("drain_busy", 32'(busy_o), 32'd1);
            @(negedge clk_i);
        end
        chk("drain_hold_no_done", 32'(dones), 32'd0);
        backend_idle_i = 1'b1;
        @(negedge clk_i);
        chk("drain_done_valid", 32'(done_valid_o),  32'd1);
        chk("drain_done_vs",    32'(done_vstart_o), 32'd1);
        @(negedge clk_i);

        // Reset in the middle of issue behaves like power-on.
        start_req(3'd7, 16'd0, 16'd4, 5'd5, 1'b1);
        @(negedge clk_i);
        chk("midreset_busy_before", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_vec(11, vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
